// File: rtl/vga_pkg.sv
// Default 640x480 @ 60 Hz raster timing shared by the timing generator
// and the threshold comparators.
package vga_pkg;

    localparam int CW       = 10;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Pixel coordinate type used on both sides of the counters.
    typedef logic [CW-1:0] vga_count_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the timing source (master) drives the raster
// outputs and receives the run enable from its consumer (slave).
// en is a level, not a handshake: while it is low the raster freezes.
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic          en;
    logic          pix_tick;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          hsync_n;
    logic          vsync_n;
    logic          video_on;
    logic          line_end;
    logic          frame_end;

    modport master (
        input  en,
        output pix_tick, hcount, vcount, hsync_n, vsync_n,
               video_on, line_end, frame_end
    );

    modport slave (
        output en,
        input  pix_tick, hcount, vcount, hsync_n, vsync_n,
               video_on, line_end, frame_end
    );
endinterface

// File: rtl/vga_axis_counter.sv
// Mod-N counter for one raster axis. wrap flags the increment that takes
// the count from N-1 back to 0 and feeds the next axis.
module vga_axis_counter #(
    parameter int CW = 10,
    parameter int N  = 800
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          wrap
);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] r_count;

    // Count register: clears on reset, advances or wraps on inc.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign wrap  = inc & (r_count == LAST);
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: horizontal/vertical counters, registered sync and
// blanking aligned with the counters, and line/frame strobes.
// Build option VGA_PIXEL_DIV_EN: defined, pix_tick comes from a 1-bit
// divider so pixels advance every second enabled clock; undefined, pix_tick
// is tied high.
module vga_timing_gen #(
    parameter int CW       = vga_pkg::CW,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  bus
);
    localparam int H_TOT_I = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT_I = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Unsigned CW-bit thresholds; sync windows are [START, END).
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic          w_pix_tick;
    logic          w_inc;
    logic [CW-1:0] w_hcount;
    logic [CW-1:0] w_vcount;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [CW-1:0] w_h_nxt;
    logic [CW-1:0] w_v_nxt;

    logic          r_hsync_n;
    logic          r_vsync_n;
    logic          r_video_on;

`ifdef VGA_PIXEL_DIV_EN
    logic          r_pix_tick;

    // Divide-by-two pixel qualifier; frozen together with the raster.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_tick <= 1'b0;
        end else if (bus.en) begin
            r_pix_tick <= ~r_pix_tick;
        end
    end

    assign w_pix_tick = r_pix_tick;
`else
    assign w_pix_tick = 1'b1;
`endif

    assign w_inc = bus.en & w_pix_tick;

    vga_axis_counter #(.CW(CW), .N(H_TOT_I)) u_h_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc),
        .count (w_hcount),
        .wrap  (w_h_wrap)
    );

    vga_axis_counter #(.CW(CW), .N(V_TOT_I)) u_v_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_h_wrap),
        .count (w_vcount),
        .wrap  (w_v_wrap)
    );

    // Position the counters will hold after an advancing edge; only
    // consumed when w_inc is high.
    always_comb begin
        w_h_nxt = w_h_wrap ? '0 : w_hcount + 1'b1;
        w_v_nxt = w_vcount;
        if (w_h_wrap) begin
            w_v_nxt = w_v_wrap ? '0 : w_vcount + 1'b1;
        end
    end

    // Sync/blanking registered from the next position so they line up with
    // the counters in the same cycle; reset values describe position (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync_n  <= 1'b1;
            r_vsync_n  <= 1'b1;
            r_video_on <= 1'b1;
        end else if (w_inc) begin
            r_hsync_n  <= ~((w_h_nxt >= HS_START) && (w_h_nxt < HS_END));
            r_vsync_n  <= ~((w_v_nxt >= VS_START) && (w_v_nxt < VS_END));
            r_video_on <= (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
        end
    end

    assign bus.pix_tick  = w_pix_tick;
    assign bus.hcount    = w_hcount;
    assign bus.vcount    = w_vcount;
    assign bus.hsync_n   = r_hsync_n;
    assign bus.vsync_n   = r_vsync_n;
    assign bus.video_on  = r_video_on;
    assign bus.line_end  = w_h_wrap;
    assign bus.frame_end = w_v_wrap;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-timing instance (short frames) and a
// default 640x480 instance run side by side, both compared every cycle with
// a position-index reference model.
module tb_vga_timing_gen;
    import vga_pkg::*;

    // Reduced timing: 25 x 15 = 375 pixels per frame.
    localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;
    localparam int S_VA = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int S_FRAME = S_HT * S_VT;
    localparam int D_FRAME = H_TOTAL * V_TOTAL;

`ifdef VGA_PIXEL_DIV_EN
    localparam bit DIV = 1'b1;
`else
    localparam bit DIV = 1'b0;
`endif

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(10)) s_if ();
    vga_timing_gen_if #(.CW(10)) d_if ();
    assign s_if.en = en;
    assign d_if.en = en;

    vga_timing_gen #(
        .CW(10),
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) u_dut_s (
        .clk (clk),
        .rst (rst),
        .bus (s_if.master)
    );

    vga_timing_gen u_dut_d (
        .clk (clk),
        .rst (rst),
        .bus (d_if.master)
    );

    // Scoreboard state: reference position index per instance and tick.
    int   checks = 0;
    int   failures = 0;
    int   p_s = 0;
    int   p_d = 0;
    logic tick_m = 1'b0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [9:0] obs, input int exp);
        checks++;
        assert (obs === 10'(exp)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected outputs derived from raster position p = v*H_TOTAL + h.
    task automatic check_dut(input string tag, input int p,
                             input int ha, input int hf, input int hs, input int hb,
                             input int va, input int vf, input int vs, input int vb,
                             input logic [9:0] hc, input logic [9:0] vc,
                             input logic hsn, input logic vsn, input logic vo,
                             input logic pt, input logic le, input logic fe);
        int   ht;
        int   vt;
        int   h;
        int   v;
        logic adv;
        logic le_exp;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        h  = p % ht;
        v  = p / ht;
        adv = en && tick_m;
        le_exp = adv && (h == ht - 1);
        chkw({tag, ".hcount"}, hc, h);
        chkw({tag, ".vcount"}, vc, v);
        chk1({tag, ".hsync_n"}, hsn, !((h >= ha + hf) && (h < ha + hf + hs)));
        chk1({tag, ".vsync_n"}, vsn, !((v >= va + vf) && (v < va + vf + vs)));
        chk1({tag, ".video_on"}, vo, (h < ha) && (v < va));
        chk1({tag, ".pix_tick"}, pt, tick_m);
        chk1({tag, ".line_end"}, le, le_exp);
        chk1({tag, ".frame_end"}, fe, le_exp && (v == vt - 1));
    endtask

    // Driver: one clock, advance the model with what the edge sampled, then
    // compare both instances away from the edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            p_s = 0;
            p_d = 0;
            tick_m = DIV ? 1'b0 : 1'b1;
        end else if (en) begin
            if (tick_m) begin
                p_s = (p_s + 1) % S_FRAME;
                p_d = (p_d + 1) % D_FRAME;
            end
            if (DIV) tick_m = !tick_m;
        end
        #1;
        check_dut("s", p_s, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB,
                  s_if.hcount, s_if.vcount, s_if.hsync_n, s_if.vsync_n,
                  s_if.video_on, s_if.pix_tick, s_if.line_end, s_if.frame_end);
        check_dut("d", p_d, H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP,
                  d_if.hcount, d_if.vcount, d_if.hsync_n, d_if.vsync_n,
                  d_if.video_on, d_if.pix_tick, d_if.line_end, d_if.frame_end);
    endtask

    // Run enabled until the reduced instance's model reaches position target.
    task automatic goto_s(input int target);
        int n;
        n = 0;
        en = 1'b1;
        while (p_s != target && n < 8 * S_FRAME) begin
            step();
            n++;
        end
    endtask

    int first_fe;
    int second_fe;
    int fe_highs;

    initial begin
        // Reset from power-up
        rst = 1'b1;
        en  = 1'b0;
        step();
        step();
        chkw("reset.hcount", s_if.hcount, 0);
        chkw("reset.vcount", s_if.vcount, 0);
        chk1("reset.hsync_n", s_if.hsync_n, 1'b1);
        chk1("reset.vsync_n", s_if.vsync_n, 1'b1);
        chk1("reset.video_on", s_if.video_on, 1'b1);
        rst = 1'b0;

        // Randomized enable pattern
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 3) != 0);
            step();
        end

        // Mid-frame reset at (12,6) held for three cycles, then restart
        goto_s(6 * S_HT + 12);
        chkw("pre_rst.hcount", s_if.hcount, 12);
        rst = 1'b1;
        repeat (3) step();
        chkw("mid_rst.hcount", s_if.hcount, 0);
        chkw("mid_rst.vcount", s_if.vcount, 0);
        chk1("mid_rst.hsync_n", s_if.hsync_n, 1'b1);
        chk1("mid_rst.vsync_n", s_if.vsync_n, 1'b1);
        chk1("mid_rst.video_on", s_if.video_on, 1'b1);
        chk1("mid_rst.frame_end", s_if.frame_end, 1'b0);
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chkw("start_seq.hcount", s_if.hcount, DIV ? i / 2 : i);
        end

        // Enable drop for five cycles at (10,5)
        goto_s(5 * S_HT + 10);
        en = 1'b0;
        repeat (5) begin
            step();
            chkw("hold.hcount", s_if.hcount, 10);
            chkw("hold.vcount", s_if.vcount, 5);
            chk1("hold.line_end", s_if.line_end, 1'b0);
        end
        en = 1'b1;

        // Line wrap at the bottom-right corner and frame period
        goto_s(S_FRAME - 1);
        first_fe  = -1;
        second_fe = -1;
        fe_highs  = 0;
        for (int c = 0; c < 8 * S_FRAME && second_fe < 0; c++) begin
            if (s_if.frame_end === 1'b1) begin
                fe_highs++;
                if (first_fe < 0) first_fe = c;
                else second_fe = c;
            end
            step();
        end
        chk1("frame.seen_two", (second_fe >= 0), 1'b1);
        chki("frame.period", second_fe - first_fe, DIV ? 2 * S_FRAME : S_FRAME);
        chki("frame.pulses", fe_highs, 2);

        // Full default-timing line from reset: hsync 656..751, blank at 640
        rst = 1'b1;
        step();
        rst = 1'b0;
        en  = 1'b1;
        repeat (DIV ? 1700 : 850) step();
        chkw("default.vcount", d_if.vcount, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
